// File: rtl/sram_stage_sequencer_pkg.sv
// rtl/sram_stage_sequencer_pkg.sv - shared state types and constants for the stage sequencer
package sram_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        S_SEQ_IDLE   = 3'd0,
        S_SEQ_START  = 3'd1,
        S_SEQ_RUN    = 3'd2,
        S_SEQ_GAP    = 3'd3,
        S_SEQ_FINISH = 3'd4,
        S_SEQ_ERROR  = 3'd5
    } seq_state_type;

    localparam int          SEQ_NUM_STAGES_DEFAULT = 3;
    localparam logic [23:0] SEQ_TIMEOUT_DEFAULT    = 24'd2_000_000;

    localparam logic [1:0]  STAGE_LOADER    = 2'd0;
    localparam logic [1:0]  STAGE_IDCT      = 2'd1;
    localparam logic [1:0]  STAGE_UPSAMPLER = 2'd2;

endpackage

// File: rtl/sram_stage_sequencer_watchdog.sv
// rtl/sram_stage_sequencer_watchdog.sv - saturating 24-bit per-stage watchdog
module seq_watchdog (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        clear,
    input  logic        enable,
    input  logic [23:0] limit,
    output logic        expired
);

    logic [23:0] count;

    // Count enabled cycles since the last clear, holding at all-ones instead of wrapping
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= 24'd0;
        end else if (clear) begin
            count <= 24'd0;
        end else if (enable && (count != 24'hFF_FFFF)) begin
            count <= count + 24'd1;
        end
    end

    // Expiry is seen during the last allowed cycle so the sequencer can leave on that edge
    always_comb begin
        expired = (count == (limit - 24'd1));
    end

endmodule

// File: rtl/sram_stage_sequencer.sv
// rtl/sram_stage_sequencer.sv - runs pipeline stages in order and grants each the shared SRAM port
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int          NUM_STAGES     = SEQ_NUM_STAGES_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Start,
    input  logic                     Abort,
    output logic [NUM_STAGES-1:0]    Stage_enable,
    input  logic [NUM_STAGES-1:0]    Stage_done,
    input  logic [NUM_STAGES*18-1:0] Stage_SRAM_address,
    input  logic [NUM_STAGES*16-1:0] Stage_SRAM_write_data,
    input  logic [NUM_STAGES-1:0]    Stage_SRAM_we_n,
    output logic [17:0]              SRAM_address,
    output logic [15:0]              SRAM_write_data,
    output logic                     SRAM_we_n,
    output logic [1:0]               Active_stage,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Error
);

    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

    seq_state_type state;
    logic [1:0]    k;
    logic          wd_expired;

    seq_watchdog u_watchdog (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clear   (state == S_SEQ_START),
        .enable  (state == S_SEQ_RUN),
        .limit   (TIMEOUT_CYCLES),
        .expired (wd_expired)
    );

    // Sequencer FSM; outputs are set on the transition into the state they describe
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_SEQ_IDLE;
            k            <= STAGE_LOADER;
            Stage_enable <= '0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            Busy         <= 1'b0;
            Active_stage <= 2'd0;
        end else begin
            Stage_enable <= '0;
            Done         <= 1'b0;
            if (Abort && (state != S_SEQ_IDLE)) begin
                state        <= S_SEQ_IDLE;
                Busy         <= 1'b0;
                Active_stage <= 2'd0;
            end else begin
                case (state)
                    S_SEQ_IDLE, S_SEQ_ERROR: begin
                        if (Start) begin
                            state        <= S_SEQ_START;
                            k            <= STAGE_LOADER;
                            Error        <= 1'b0;
                            Busy         <= 1'b1;
                            Active_stage <= STAGE_LOADER;
                            Stage_enable <= NUM_STAGES'(1);
                        end
                    end
                    S_SEQ_START: begin
                        state <= S_SEQ_RUN;
                    end
                    S_SEQ_RUN: begin
                        if (Stage_done[k]) begin
                            Active_stage <= 2'd0;
                            if (k == LAST_STAGE) begin
                                state <= S_SEQ_FINISH;
                                Done  <= 1'b1;
                            end else begin
                                state <= S_SEQ_GAP;
                            end
                        end else if (wd_expired) begin
                            state        <= S_SEQ_ERROR;
                            Error        <= 1'b1;
                            Busy         <= 1'b0;
                            Active_stage <= 2'd0;
                        end
                    end
                    S_SEQ_GAP: begin
                        state        <= S_SEQ_START;
                        k            <= k + 2'd1;
                        Active_stage <= k + 2'd1;
                        Stage_enable <= NUM_STAGES'(1) << (k + 2'd1);
                    end
                    S_SEQ_FINISH: begin
                        state <= S_SEQ_IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_SEQ_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Zero-latency SRAM mux: only the owning stage reaches the port, otherwise it is parked idle
    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        if ((state == S_SEQ_START) || (state == S_SEQ_RUN)) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (k == 2'(i)) begin
                    SRAM_address    = Stage_SRAM_address[i*18 +: 18];
                    SRAM_write_data = Stage_SRAM_write_data[i*16 +: 16];
                    SRAM_we_n       = Stage_SRAM_we_n[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// tb/tb_sram_stage_sequencer.sv - directed self-checking bench for sram_stage_sequencer
module tb_sram_stage_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  stage_enable;
    logic [2:0]  stage_done;
    logic [53:0] stage_addr;
    logic [47:0] stage_wdata;
    logic [2:0]  stage_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we_n;
    logic [1:0]  active_stage;
    logic        busy;
    logic        done;
    logic        error;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;
    int done_seen     = 0;
    int last_en       = 0;

    sram_stage_sequencer #(
        .NUM_STAGES     (3),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .Clock                 (clk),
        .Resetn                (rst_n),
        .Start                 (start),
        .Abort                 (abort),
        .Stage_enable          (stage_enable),
        .Stage_done            (stage_done),
        .Stage_SRAM_address    (stage_addr),
        .Stage_SRAM_write_data (stage_wdata),
        .Stage_SRAM_we_n       (stage_we_n),
        .SRAM_address          (sram_addr),
        .SRAM_write_data       (sram_wdata),
        .SRAM_we_n             (sram_we_n),
        .Active_stage          (active_stage),
        .Busy                  (busy),
        .Done                  (done),
        .Error                 (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else checks_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_parked(input string tag);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_data"}, 32'(sram_wdata), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        stage_done  = 3'b000;
        stage_addr  = {18'd7, 18'd146944, 18'd100};
        stage_wdata = {16'h2222, 16'hABCD, 16'h1111};
        stage_we_n  = 3'b000;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_enable", 32'(stage_enable), 32'd0);
        chk("rst_active", 32'(active_stage), 32'd0);
        chk_parked("rst");
        rst_n = 1'b1;
        tick();

        // Full sequence, each stage done 10 cycles after its enable; stray done[2] during stage 0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("seq_enable", 32'(stage_enable), 32'(1 << s));
            chk("seq_active", 32'(active_stage), 32'(s));
            chk("seq_busy", 32'(busy), 32'd1);
            if (s > 0) chk("seq_spacing", 32'(cyc - last_en), 32'd12);
            last_en = cyc;
            for (int i = 1; i <= 10; i++) begin
                tick();
                stage_done = 3'b000;
                if (i == 10) stage_done = 3'(1 << s);
                if (s == 0 && i == 3) stage_done = 3'b100;
                if (i == 5 && s == 1) begin
                    chk("s1_addr", 32'(sram_addr), 32'd146944);
                    chk("s1_we_n", 32'(sram_we_n), 32'd0);
                    chk("s1_data", 32'(sram_wdata), 32'hABCD);
                    chk("s1_active", 32'(active_stage), 32'd1);
                end
                if (i == 5 && s == 2) chk("s2_addr", 32'(sram_addr), 32'd7);
            end
            tick();
            stage_done = 3'b000;
            if (s < 2) begin
                chk_parked("gap");
                chk("gap_enable", 32'(stage_enable), 32'd0);
                chk("gap_busy", 32'(busy), 32'd1);
                tick();
            end else begin
                chk("fin_done", 32'(done), 32'd1);
                chk("fin_busy", 32'(busy), 32'd1);
                tick();
                chk("post_done", 32'(done), 32'd0);
                chk("post_busy", 32'(busy), 32'd0);
            end
        end
        chk("seq_done_count", 32'(done_seen), 32'd1);

        // Watchdog: stage 0 never completes, limit 16
        done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("wd_last_run_error", 32'(error), 32'd0);
        chk("wd_last_run_busy", 32'(busy), 32'd1);
        tick();
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        chk_parked("wd");
        tick();
        tick();
        chk("wd_sticky", 32'(error), 32'd1);
        chk("wd_no_done", 32'(done_seen), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_restart_error", 32'(error), 32'd0);
        chk("wd_restart_enable", 32'(stage_enable), 32'd1);
        chk("wd_restart_active", 32'(active_stage), 32'd0);

        // Abort together with the active stage's done
        tick();
        tick();
        chk("ab_we_n_before", 32'(sram_we_n), 32'd0);
        abort      = 1'b1;
        stage_done = 3'b001;
        tick();
        abort      = 1'b0;
        stage_done = 3'b000;
        chk("ab_busy", 32'(busy), 32'd0);
        chk_parked("ab");
        tick();
        chk("ab_no_done", 32'(done_seen), 32'd0);

        // Reset while stage 2 is running
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stage_done = 3'b001;
        tick();
        stage_done = 3'b000;
        tick();
        tick();
        stage_done = 3'b010;
        tick();
        stage_done = 3'b000;
        tick();
        tick();
        chk("rs_active_pre", 32'(active_stage), 32'd2);
        chk("rs_addr_pre", 32'(sram_addr), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_active", 32'(active_stage), 32'd0);
        chk("rs_enable", 32'(stage_enable), 32'd0);
        chk_parked("rs");
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rs_idle_busy", 32'(busy), 32'd0);
        chk("rs_idle_enable", 32'(stage_enable), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_restart_enable", 32'(stage_enable), 32'd1);
        chk("rs_restart_busy", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
